// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush squashing
// and saturating stall/bubble performance counters.
module id_ex_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RW   = 5,
  parameter int unsigned CW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic [1:0]      id_alu_op,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [RW-1:0]   ex_rs1,
  output logic [RW-1:0]   ex_rs2,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic            stall,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [CW-1:0]   stall_cnt,
  output logic [CW-1:0]   bubble_cnt
);

  logic          hazard;
  logic          capture;
  logic          bubble;
  logic          ctrl_en;
  logic [CW-1:0] stall_cnt_d;
  logic [CW-1:0] bubble_cnt_d;

  // A load in EX feeding the ID instruction; x0 is hard-wired so never conflicts.
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign stall       = hazard & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  assign capture = ~flush & ~stall;
  assign bubble  = flush | stall | ~id_valid;
  // Invalid slots must never write registers or memory.
  assign ctrl_en = capture & id_valid;

  always_comb begin
    stall_cnt_d  = stall_cnt;
    bubble_cnt_d = bubble_cnt;
    if (stall && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt + CW'(1);
    end
    if (bubble && (bubble_cnt != {CW{1'b1}})) begin
      bubble_cnt_d = bubble_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      stall_cnt     <= '0;
      bubble_cnt    <= '0;
    end else begin
      ex_valid      <= ctrl_en;
      ex_pc         <= capture ? id_pc  : '0;
      ex_rd1        <= capture ? id_rd1 : '0;
      ex_rd2        <= capture ? id_rd2 : '0;
      ex_imm        <= capture ? id_imm : '0;
      ex_rs1        <= capture ? id_rs1 : '0;
      ex_rs2        <= capture ? id_rs2 : '0;
      ex_rd         <= capture ? id_rd  : '0;
      ex_reg_write  <= ctrl_en & id_reg_write;
      ex_mem_read   <= ctrl_en & id_mem_read;
      ex_mem_write  <= ctrl_en & id_mem_write;
      ex_mem_to_reg <= ctrl_en & id_mem_to_reg;
      ex_alu_src    <= ctrl_en & id_alu_src;
      ex_branch     <= ctrl_en & id_branch;
      ex_alu_op     <= ctrl_en ? id_alu_op : 2'b00;
      stall_cnt     <= stall_cnt_d;
      bubble_cnt    <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: per-cycle comparison against a slot-level model plus
// directed scenarios, with a second CW=4 instance for counter saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_alu_src, id_branch, flush;
  logic [63:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alu_op;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_alu_src, ex_branch, stall, pc_write, if_id_write;
  logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  ex_alu_op;
  logic [31:0] stall_cnt, bubble_cnt;

  logic        s_valid, s_rw, s_mr, s_mw, s_m2r, s_as, s_br, s_stall, s_pcw, s_ifw;
  logic [63:0] s_pc, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_op;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .stall(stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .flush(flush),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_reg_write(s_rw),
    .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_mem_to_reg(s_m2r),
    .ex_alu_src(s_as), .ex_branch(s_br), .ex_alu_op(s_op), .stall(s_stall),
    .pc_write(s_pcw), .if_id_write(s_ifw), .stall_cnt(s_stall_cnt),
    .bubble_cnt(s_bubble_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the EX slot as one record, counters as unbounded integers clipped on compare.
  typedef struct packed {
    logic        valid;
    logic [63:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, m2r, as_, br;
    logic [1:0]  op;
  } slot_t;

  slot_t   m_ex;
  longint  m_stalls, m_bubbles;

  function automatic logic m_load_use();
    return id_valid && m_ex.valid && m_ex.mr && (m_ex.rd != 0) &&
           (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
  endfunction

  function automatic longint clip(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex = '0;
      m_stalls = 0;
      m_bubbles = 0;
    end else begin
      logic st;
      st = m_load_use() && !flush;
      if (flush || st) begin
        m_ex = '0;
        m_bubbles++;
        if (st) m_stalls++;
      end else begin
        m_ex = '{valid: id_valid, pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
                 rs1: id_rs1, rs2: id_rs2, rd: id_rd, rw: id_reg_write, mr: id_mem_read,
                 mw: id_mem_write, m2r: id_mem_to_reg, as_: id_alu_src, br: id_branch,
                 op: id_alu_op};
        if (!id_valid) begin
          {m_ex.rw, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.as_, m_ex.br, m_ex.op} = '0;
          m_bubbles++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = m_load_use() && !flush;
    check("m_valid", ex_valid, m_ex.valid);
    check("m_pc", ex_pc, m_ex.pc);
    check("m_rd1", ex_rd1, m_ex.rd1);
    check("m_rd2", ex_rd2, m_ex.rd2);
    check("m_imm", ex_imm, m_ex.imm);
    check("m_regs", {ex_rs1, ex_rs2, ex_rd}, {m_ex.rs1, m_ex.rs2, m_ex.rd});
    check("m_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                     ex_branch, ex_alu_op},
          {m_ex.rw, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.as_, m_ex.br, m_ex.op});
    check("m_stall", {stall, pc_write, if_id_write}, {exp_stall, !exp_stall, !exp_stall});
    check("m_stall_cnt", stall_cnt, clip(m_stalls, 64'hFFFF_FFFF));
    check("m_bubble_cnt", bubble_cnt, clip(m_bubbles, 64'hFFFF_FFFF));
    check("m4_stall", s_stall, exp_stall);
    check("m4_stall_cnt", s_stall_cnt, clip(m_stalls, 15));
    check("m4_bubble_cnt", s_bubble_cnt, clip(m_bubbles, 15));
  end

  task automatic clear_id();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0; id_alu_src = 0; id_branch = 0;
    id_alu_op = 0; flush = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [63:0] pc);
    clear_id();
    id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
    id_alu_src = 1; id_rd = rd; id_rs1 = 5'd1; id_pc = pc; id_imm = 64'h10;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sc, bc;
    clear_id();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_stall", stall, 0);
    #2 rst_n = 1;
    step();

    // Plain ALU instruction
    id_valid = 1; id_pc = 64'h100; id_rd1 = 24; id_rd2 = 20; id_imm = 8;
    id_rd = 5; id_rs1 = 2; id_rs2 = 4; id_alu_op = 2; id_reg_write = 1;
    step();
    check("alu_ex_valid", ex_valid, 1);
    check("alu_ex_pc", ex_pc, 64'h100);
    check("alu_ex_rd1", ex_rd1, 24);
    check("alu_ex_rd2", ex_rd2, 20);
    check("alu_ex_imm", ex_imm, 8);
    check("alu_ex_rd", ex_rd, 5);
    check("alu_ex_alu_op", ex_alu_op, 2);
    check("alu_ex_reg_write", ex_reg_write, 1);
    check("alu_stall", stall, 0);

    // Load-use on rs1
    load(5'd3, 64'h104);
    step();
    clear_id();
    id_valid = 1; id_rs1 = 3; id_rs2 = 8; id_rd = 6; id_reg_write = 1; id_pc = 64'h108;
    #1;
    check("lu_stall", stall, 1);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    bc = bubble_cnt;
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", {ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_alu_src}, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_bubble_cnt", bubble_cnt, bc + 1);
    check("lu_stall_drop", stall, 0);
    step();
    check("lu_dep_valid", ex_valid, 1);
    check("lu_dep_rd", ex_rd, 6);
    check("lu_dep_pc", ex_pc, 64'h108);

    // Load to x0 never stalls
    load(5'd0, 64'h10c);
    step();
    clear_id();
    id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 7; id_reg_write = 1;
    #1;
    check("x0_stall", stall, 0);
    step();
    check("x0_ex_valid", ex_valid, 1);
    check("x0_ex_rd", ex_rd, 7);

    // Hazard coinciding with flush
    load(5'd4, 64'h110);
    step();
    clear_id();
    id_valid = 1; id_rs1 = 4; id_rd = 9; id_reg_write = 1; flush = 1;
    #1;
    check("fl_stall", stall, 0);
    check("fl_pc_write", pc_write, 1);
    sc = stall_cnt;
    bc = bubble_cnt;
    step();
    check("fl_ex_valid", ex_valid, 0);
    check("fl_stall_cnt", stall_cnt, sc);
    check("fl_bubble_cnt", bubble_cnt, bc + 1);
    flush = 0;

    // Asynchronous reset while stalling
    load(5'd9, 64'h120);
    step();
    clear_id();
    id_valid = 1; id_rs2 = 9; id_rd = 10; id_reg_write = 1;
    #1;
    check("ar_pre_stall", stall, 1);
    check("ar_pre_valid", ex_valid, 1);
    #1 rst_n = 0;
    #1;
    check("ar_ex_valid", ex_valid, 0);
    check("ar_ex_pc", ex_pc, 0);
    check("ar_ex_rd", ex_rd, 0);
    check("ar_ex_mem_read", ex_mem_read, 0);
    check("ar_stall", stall, 0);
    check("ar_stall_cnt", stall_cnt, 0);
    check("ar_bubble_cnt", bubble_cnt, 0);
    clear_id();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step();

    // Self-dependent load chain: stalls every other cycle
    load(5'd3, 64'h200);
    id_rs1 = 3;
    repeat (40) step();
    check("sat_stall_cnt32", stall_cnt, 20);
    check("sat_stall_cnt4", s_stall_cnt, 15);
    repeat (2) step();
    check("sat_hold_cnt4", s_stall_cnt, 15);
    check("sat_cnt32_more", stall_cnt, 21);

    clear_id();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 64-bit five-stage core.
- Captures register-file read data (RD1/RD2, valid before each posedge because the register file reads on negedge), immediate, PC, register numbers and decoded control, and presents them to EX.
- Contains load-use hazard detection: stalls PC/IF-ID and inserts a bubble into EX.
- Honours a branch flush from the later stages.
- Keeps saturating stall and bubble counters for performance analysis.

Parameters:
- XLEN, 64, datapath width (register data, immediate, PC).
- RW, 5, register-number width.
- CW, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1, id_rs2, id_rd  in  RW  source/destination register numbers.
- id_rd1, id_rd2  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1  decoded control.
- id_alu_op  in  2  ALU op class.
- flush  in  1  branch taken; squash ID instruction.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered data.
- ex_rs1, ex_rs2, ex_rd  out  RW  registered register numbers (feed forwarding unit).
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1  registered control.
- ex_alu_op  out  2  registered ALU op.
- stall  out  1  combinational load-use hazard indication.
- pc_write, if_id_write  out  1  combinational; equal to ~stall.
- stall_cnt, bubble_cnt  out  CW  performance counters.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ex_* outputs are 0. ex_valid=0.
  - Both counters are 0.
  - stall is 0, because it depends on ex_valid=0.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- stall = hazard & ~flush.
- Register x0 never causes a hazard.
- Posedge update, priority order:
  1. flush=1: load bubble. ex_valid=0 and all ex control bits = 0. Data/register fields are don't-care; they are loaded with 0. bubble_cnt increments.
  2. else stall=1: load bubble as above. stall_cnt and bubble_cnt both increment. ID contents are held upstream because if_id_write=0. The next cycle re-evaluates with ex_valid=0, so the stall lasts exactly 1 cycle per load-use pair.
  3. else: capture all id_* fields. ex_valid=id_valid.
  4. If id_valid=0 in case 3, control bits are forced to 0 so invalid slots never write registers or memory. bubble_cnt increments.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Throughput: 1 instruction per cycle absent hazards.
- Counters saturate at all-ones and do not wrap.
- Simultaneous flush and hazard: flush wins. stall=0, pc_write=1. Only bubble_cnt increments.
- Reset asserted mid-stall: the bubble is discarded, outputs return to reset values immediately, and stall drops with ex_valid.
- No internal forwarding. Write-through is provided by the register file (write precedes read at the same negedge).

Test Plan:
- Reset release, then id_valid=1, rd1=24, rd2=20, imm=8, rd=5, alu_op=2, reg_write=1 -> next posedge: ex_valid=1, ex_rd1=24, ex_rd2=20, ex_imm=8, ex_rd=5, ex_reg_write=1; stall=0.
- Load (mem_read=1, rd=3) in EX, then ID instruction with rs1=3 -> stall=1, pc_write=0, if_id_write=0. Next posedge: ex_valid=0, all control 0, stall_cnt=1, bubble_cnt=1. Following posedge: the dependent instruction enters EX with stall=0.
- Load with rd=0 in EX and ID rs2=0 -> stall stays 0. Instruction enters EX normally.
- Load-use hazard and flush=1 in the same cycle -> stall=0, pc_write=1. Next posedge: bubble, stall_cnt unchanged, bubble_cnt +1.
- Assert rst_n=0 asynchronously between clock edges while ex_valid=1 and stall=1 -> all ex_* outputs, counters and stall go to 0 immediately, without waiting for clk.
- CW=4 override: force 20 consecutive load-use stalls -> stall_cnt saturates at 15 and holds.
